instruction_fetch: RTL and testbench

- First pipeline stage of the MIPS core. Sits directly upstream of decode.
- Holds the PC and a word-addressed instruction memory, which the debug unit loads before execution.
- Drives the IF/ID register (instruction, PC+4, valid) that decode consumes.
- Accepts stall and jump/branch redirect from downstream, and stops on a HALT instruction.

---
 rtl/instruction_fetch.sv | 111 +++++++++++
 tb/tb_instruction_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, word-addressed instruction memory (loaded by the
// debug unit while in LOAD) and the IF/ID register consumed by decode.
module instruction_fetch #(
    parameter int         len         = 32,
    parameter int         ram_len     = 10,
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_start,
    input  logic               in_pc_enable,
    input  logic               in_pc_src,
    input  logic [len-1:0]     in_pc_jump,
    input  logic               in_wr_enable,
    input  logic [ram_len-1:0] in_wr_addr,
    input  logic [len-1:0]     in_wr_data,
    output logic [len-1:0]     out_pc_branch,
    output logic [len-1:0]     out_instruccion,
    output logic               out_valid,
    output logic               out_halt,
    output logic [len-1:0]     out_pc
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t         state_q;
    logic [len-1:0] pc_q;
    logic [len-1:0] instr_q;
    logic [len-1:0] pc_branch_q;
    logic           valid_q;
    logic           halt_q;

    // Instruction memory is deliberately not reset so a program survives reset.
    logic [len-1:0] mem_q [0:(1<<ram_len)-1];

    logic [len-1:0] fetch_word_d;
    logic [len-1:0] pc_plus4_d;
    logic [len-1:0] jump_target_d;
    logic           is_halt_d;

    // Word index drops the byte-offset bits; upper PC bits alias.
    assign fetch_word_d  = mem_q[pc_q[ram_len+1:2]];
    assign pc_plus4_d    = pc_q + len'(4);
    assign jump_target_d = in_pc_jump & ~len'(3);
    assign is_halt_d     = (fetch_word_d[len-1 -: 6] == HALT_OPCODE);

    // Debug-unit program load; only honoured before fetching starts.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD && in_wr_enable) begin
            mem_q[in_wr_addr] <= in_wr_data;
        end
    end

    // Fetch FSM with the PC and IF/ID register as its registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_LOAD;
            pc_q        <= '0;
            instr_q     <= '0;
            pc_branch_q <= '0;
            valid_q     <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_start) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_pc_src) begin
                        // Redirect wins over stall and over a HALT sitting at PC.
                        pc_q        <= jump_target_d;
                        instr_q     <= '0;
                        pc_branch_q <= '0;
                        valid_q     <= 1'b0;
                    end else if (in_pc_enable) begin
                        instr_q     <= fetch_word_d;
                        pc_branch_q <= pc_plus4_d;
                        valid_q     <= 1'b1;
                        if (is_halt_d) begin
                            halt_q  <= 1'b1;
                            state_q <= ST_HALTED;
                        end else begin
                            pc_q <= pc_plus4_d;
                        end
                    end
                end
                ST_HALTED: begin
                    // HALT stays valid for exactly one cycle, then a frozen NOP.
                    instr_q <= '0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign out_pc          = pc_q;
    assign out_instruccion = instr_q;
    assign out_pc_branch   = pc_branch_q;
    assign out_valid       = valid_q;
    assign out_halt        = halt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// traffic, all compared against a behavioural model of the fetch rules.
module tb_instruction_fetch;

    localparam int LEN   = 32;
    localparam int RAML  = 10;
    localparam int WORDS = 1 << RAML;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_start = 1'b0;
    logic            in_pc_enable = 1'b0;
    logic            in_pc_src = 1'b0;
    logic [LEN-1:0]  in_pc_jump = '0;
    logic            in_wr_enable = 1'b0;
    logic [RAML-1:0] in_wr_addr = '0;
    logic [LEN-1:0]  in_wr_data = '0;
    logic [LEN-1:0]  out_pc_branch;
    logic [LEN-1:0]  out_instruccion;
    logic            out_valid;
    logic            out_halt;
    logic [LEN-1:0]  out_pc;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch #(.len(LEN), .ram_len(RAML), .HALT_OPCODE(6'b111111)) dut (
        .clk(clk), .reset(reset), .in_start(in_start), .in_pc_enable(in_pc_enable),
        .in_pc_src(in_pc_src), .in_pc_jump(in_pc_jump), .in_wr_enable(in_wr_enable),
        .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data), .out_pc_branch(out_pc_branch),
        .out_instruccion(out_instruccion), .out_valid(out_valid), .out_halt(out_halt),
        .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    // Reference model: phase is "load", "run" or "halted"
    logic [31:0] m_mem [0:WORDS-1];
    string       m_phase;
    logic [31:0] m_pc, m_instr, m_pcb;
    logic        m_valid, m_halt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = "load";
        m_pc = 0; m_instr = 0; m_pcb = 0; m_valid = 0; m_halt = 0;
    endtask

    // One rising edge worth of behaviour, from the current inputs.
    task automatic model_edge();
        logic [31:0] w;
        if (m_phase == "load") begin
            if (in_wr_enable) m_mem[int'(in_wr_addr)] = in_wr_data;
            if (in_start) m_phase = "run";
        end else if (m_phase == "run") begin
            if (in_pc_src) begin
                m_pc = (in_pc_jump / 4) * 4;
                m_instr = 0; m_valid = 0; m_pcb = 0;
            end else if (in_pc_enable) begin
                w = m_mem[(m_pc / 4) % WORDS];
                m_instr = w;
                m_pcb   = m_pc + 32'd4;
                m_valid = 1;
                if ((w >> 26) == 32'h3F) begin
                    m_halt  = 1;
                    m_phase = "halted";
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end else begin
            m_instr = 0; m_valid = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    out_pc,          m_pc);
        chk({tag, ".instr"}, out_instruccion, m_instr);
        chk({tag, ".pcb"},   out_pc_branch,   m_pcb);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        chk({tag, ".halt"},  {31'd0, out_halt},  {31'd0, m_halt});
    endtask

    // Inputs are set at the falling edge; this advances one clock and checks.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle_inputs();
        in_start = 0; in_pc_enable = 0; in_pc_src = 0; in_pc_jump = 0;
        in_wr_enable = 0; in_wr_addr = 0; in_wr_data = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 0;
        model_reset();
        @(negedge clk);
        check_all("reset");
        reset = 1;
    endtask

    task automatic write_word(input int addr, input logic [31:0] data);
        in_wr_enable = 1; in_wr_addr = RAML'(addr); in_wr_data = data;
        cyc("load");
        in_wr_enable = 0;
    endtask

    task automatic start_run();
        in_start = 1;
        cyc("start");
        in_start = 0;
    endtask

    task automatic advance(input int n);
        in_pc_enable = 1;
        for (int i = 0; i < n; i++) cyc("adv");
    endtask

    task automatic redirect(input logic [31:0] tgt, input logic en);
        in_pc_src = 1; in_pc_jump = tgt; in_pc_enable = en;
        cyc("redir");
        in_pc_src = 0;
    endtask

    function automatic logic [31:0] plain_word();
        logic [31:0] r;
        r = $urandom();
        r[31:26] = 6'h08;
        return r;
    endfunction

    initial begin
        model_reset();
        for (int i = 0; i < WORDS; i++) m_mem[i] = 'x;
        @(negedge clk);
        check_all("reset0");
        reset = 1;

        // Fill the whole memory with non-HALT words, then the test program.
        for (int i = 0; i < WORDS; i++) write_word(i, plain_word());
        write_word(0, 32'h20010005);
        write_word(1, 32'h20020007);
        write_word(2, 32'h00221820);
        write_word(3, 32'hFC000000);

        // Straight-line program up to HALT
        start_run();
        advance(4);
        chk("prog.halt_word", out_instruccion, 32'hFC000000);
        chk("prog.halt_pcb", out_pc_branch, 32'd16);
        chk("prog.halt_pc", out_pc, 32'd12);
        chk("prog.halt_flag", {31'd0, out_halt}, 32'd1);
        advance(1);
        chk("prog.valid_drop", {31'd0, out_valid}, 32'd0);
        in_start = 1; in_pc_src = 1; in_pc_jump = 32'h40;
        cyc("halted_frozen");
        chk("prog.frozen_pc", out_pc, 32'd12);
        idle_inputs();

        // Stall at PC=4 for three cycles
        do_reset();
        start_run();
        advance(1);
        in_pc_enable = 0;
        for (int i = 0; i < 3; i++) cyc("stall");
        chk("stall.pc", out_pc, 32'd4);
        chk("stall.instr", out_instruccion, 32'h20010005);
        advance(1);
        chk("stall.resume", out_instruccion, 32'h20020007);

        // Redirect with stall on the same edge
        do_reset();
        start_run();
        redirect(32'h0000000E, 1'b0);
        chk("redir.pc", out_pc, 32'h0000000C);
        advance(1);
        chk("redir.mem3", out_instruccion, 32'hFC000000);

        // Redirect beats HALT at PC
        do_reset();
        start_run();
        advance(3);
        redirect(32'h00000020, 1'b1);
        chk("redir_halt.flag", {31'd0, out_halt}, 32'd0);
        chk("redir_halt.pc", out_pc, 32'h20);
        advance(1);

        // Write attempt in RUN, aliasing jump, PC wrap
        in_wr_enable = 1; in_wr_addr = 0; in_wr_data = 32'hFFFFFFFF;
        cyc("run_write");
        in_wr_enable = 0;
        redirect(32'h00001000, 1'b1);
        advance(1);
        chk("alias.word0", out_instruccion, 32'h20010005);
        redirect(32'hFFFFFFFC, 1'b1);
        advance(1);
        chk("wrap.pcb", out_pc_branch, 32'd0);
        chk("wrap.pc", out_pc, 32'd0);

        // Asynchronous reset mid-cycle with PC=8
        do_reset();
        start_run();
        advance(2);
        chk("areset.pre_pc", out_pc, 32'd8);
        #2 reset = 0;
        #1;
        model_reset();
        chk("areset.pc", out_pc, 32'd0);
        chk("areset.instr", out_instruccion, 32'd0);
        chk("areset.pcb", out_pc_branch, 32'd0);
        chk("areset.valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        idle_inputs();
        reset = 1;
        write_word(40, 32'h12345678);
        start_run();
        advance(1);
        chk("areset.keep_mem", out_instruccion, 32'h20010005);
        redirect(32'd160, 1'b1);
        advance(1);
        chk("areset.new_word", out_instruccion, 32'h12345678);

        // Random traffic against the model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int k = 0; k < 8; k++) begin
                logic [31:0] d;
                d = (($urandom_range(0, 3) == 0) ? 32'hFC000000 : plain_word()) | 32'($urandom_range(0, 255));
                write_word($urandom_range(0, 63), d);
            end
            start_run();
            for (int c = 0; c < 60; c++) begin
                in_pc_src    = ($urandom_range(0, 5) == 0);
                in_pc_jump   = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 255));
                in_pc_enable = ($urandom_range(0, 3) != 0);
                in_start     = $urandom_range(0, 1);
                in_wr_enable = $urandom_range(0, 1);
                in_wr_addr   = RAML'($urandom_range(0, 63));
                in_wr_data   = $urandom();
                cyc("rand");
            end
            idle_inputs();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
